// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises a captured pattern MSB-first, repeated N times.
// Optional inter-frame zero gap when SEQ_TX_GAP_EN is defined.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start_valid   request in; start_ready high only while idle
//   pattern, len  frame bits and length (len clamped to PAT_W)
//   repeat_cnt    extra frame repetitions 0..15 ("repeat" is a keyword)
//   dout          serial bit, 0 whenever dout_valid is low
//   dout_valid    dout carries a bit this cycle
//   busy, done    request in progress / one-cycle completion pulse
module seq_pattern_tx #(
  parameter int PAT_W    = 8,
  parameter int LEN_W    = 4,
  parameter int GAP_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       repeat_cnt,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  if (LEN_W < $clog2(PAT_W + 1)) begin : g_bad_len
    $error("LEN_W too narrow for PAT_W");
  end
  if (GAP_BITS < 1 || GAP_BITS > 15) begin : g_bad_gap
    $error("GAP_BITS out of range 1..15");
  end

`ifdef SEQ_TX_GAP_EN
  typedef enum logic [1:0] {
    IDLE, SHIFT, GAP, DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE, SHIFT, DONE
  } state_e;
`endif

  state_e           state_q, state_d;
  // pat_q holds the frame left-aligned so the
  // next bit is always the MSB of a shift reg
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rep_q, rep_d;
  logic             dout_q, dout_d;
  logic             vld_q, vld_d;
`ifdef SEQ_TX_GAP_EN
  logic [3:0]       gap_q, gap_d;
`endif

  logic [LEN_W-1:0] len_c;
  logic [PAT_W-1:0] aligned;
  logic             load;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    dout_d  = 1'b0;
    vld_d   = 1'b0;
    load    = 1'b0;
`ifdef SEQ_TX_GAP_EN
    gap_d   = gap_q;
`endif
    len_c = (len > LEN_W'(PAT_W)) ?
            LEN_W'(PAT_W) : len;
    aligned = pattern << (LEN_W'(PAT_W) - len_c);

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          pat_d = aligned;
          len_d = len_c;
          rep_d = repeat_cnt;
          if (len_c == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
            dout_d  = aligned[PAT_W-1];
            vld_d   = 1'b1;
            sh_d    = aligned << 1;
            cnt_d   = len_c - 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          dout_d = sh_q[PAT_W-1];
          vld_d  = 1'b1;
          sh_d   = sh_q << 1;
          cnt_d  = cnt_q - 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q - 1'b1;
`ifdef SEQ_TX_GAP_EN
          state_d = GAP;
          vld_d   = 1'b1;
          gap_d   = 4'(GAP_BITS - 1);
`else
          load = 1'b1;
`endif
        end else begin
          state_d = DONE;
        end
      end
`ifdef SEQ_TX_GAP_EN
      GAP: begin
        if (gap_q == '0) begin
          load = 1'b1;
        end else begin
          vld_d = 1'b1;
          gap_d = gap_q - 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // restart the captured frame from its MSB
    if (load) begin
      state_d = SHIFT;
      dout_d  = pat_q[PAT_W-1];
      vld_d   = 1'b1;
      sh_d    = pat_q << 1;
      cnt_d   = len_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
`ifdef SEQ_TX_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dout        = dout_q;
  assign dout_valid  = vld_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: table vectors, random requests vs a queue model,
// and a mid-frame reset sequence for seq_pattern_tx.
module tb_seq_pattern_tx;

  localparam int PAT_W    = 8;
  localparam int LEN_W    = 4;
  localparam int GAP_BITS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] repeat_cnt = '0;
  logic       start_ready, dout, dout_valid;
  logic       busy, done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [3:0]  rep;
    bit          hold;
    int          n;
    logic [31:0] bits;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .PAT_W(PAT_W), .LEN_W(LEN_W),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .pattern(pattern), .len(len),
    .repeat_cnt(repeat_cnt),
    .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .done(done)
  );

  function automatic logic [4:0] outs();
    return {start_ready, busy, done,
            dout_valid, dout};
  endfunction

  task automatic chk(string name,
                     logic [4:0] act,
                     logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: rdy/busy/done/vld/dout got %b want %b",
               name, act, req);
    end
  endtask

  // reference: frame bits MSB first, repeated,
  // with optional zero gaps between frames
  task automatic build(logic [7:0] p, int l, int r);
    int lc;
    lc = (l > PAT_W) ? PAT_W : l;
    exp_q.delete();
    if (lc == 0) return;
    for (int f = 0; f <= r; f++) begin
      for (int i = lc - 1; i >= 0; i--)
        exp_q.push_back(p[i]);
`ifdef SEQ_TX_GAP_EN
      if (f < r)
        for (int g = 0; g < GAP_BITS; g++)
          exp_q.push_back(1'b0);
`endif
    end
  endtask

  // one request; exp_q holds expected bits
  task automatic run_req(string name,
                         logic [7:0] p,
                         logic [3:0] l,
                         logic [3:0] r,
                         bit hold);
    int n;
    logic [4:0] want;
    n = exp_q.size();
    @(negedge clk);
    chk({name, " ready"}, outs(), 5'b10000);
    start_valid = 1'b1;
    pattern = p;
    len = l;
    repeat_cnt = r;
    @(posedge clk);
    #1;
    if (!hold) start_valid = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k <= n)
        want = {4'b0101, exp_q[k-1]};
      else if (k == n + 1)
        want = 5'b01100;
      else
        want = 5'b10000;
      chk($sformatf("%s c%0d", name, k),
          outs(), want);
      if (hold && k <= n) begin
        pattern = 8'($urandom);
        len = 4'($urandom);
        repeat_cnt = 4'($urandom);
      end
      if (k == n + 1) start_valid = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{8'h08, 4'd4, 4'd0, 1'b0,
               4, 32'b1000};
    tbl[2] = '{8'hA5, 4'd0, 4'd5, 1'b0,
               0, 32'b0};
    tbl[3] = '{8'hA5, 4'd12, 4'd0, 1'b0,
               8, 32'b10100101};
`ifdef SEQ_TX_GAP_EN
    tbl[1] = '{8'h08, 4'd4, 4'd2, 1'b0,
               16, 32'b1000001000001000};
    tbl[4] = '{8'hC3, 4'd8, 4'd1, 1'b1,
               18, 32'b110000110011000011};
    tbl[5] = '{8'h01, 4'd1, 4'd3, 1'b0,
               10, 32'b1001001001};
`else
    tbl[1] = '{8'h08, 4'd4, 4'd2, 1'b0,
               12, 32'b100010001000};
    tbl[4] = '{8'hC3, 4'd8, 4'd1, 1'b1,
               16, 32'hC3C3};
    tbl[5] = '{8'h01, 4'd1, 4'd3, 1'b0,
               4, 32'b1111};
`endif

    #12;
    chk("reset", {1'b0, busy, done,
                  dout_valid, dout}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      exp_q.delete();
      for (int b = tbl[i].n - 1; b >= 0; b--)
        exp_q.push_back(tbl[i].bits[b]);
      run_req($sformatf("tbl%0d", i),
              tbl[i].pat, tbl[i].len,
              tbl[i].rep, tbl[i].hold);
    end

    for (int t = 0; t < 30; t++) begin
      logic [7:0] p;
      logic [3:0] l, r;
      bit h;
      p = 8'($urandom);
      l = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 3));
      h = 1'($urandom);
      build(p, int'(l), int'(r));
      run_req($sformatf("rnd%0d", t),
              p, l, r, h);
    end

    // reset during bit 2 of a 4-bit frame
    @(negedge clk);
    start_valid = 1'b1;
    pattern = 8'h0C;
    len = 4'd4;
    repeat_cnt = 4'd3;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    chk("mid bit1", outs(), 5'b01011);
    @(negedge clk);
    chk("mid bit2", outs(), 5'b01011);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid async rst", outs(), 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post rst %0d", k),
          outs(), 5'b10000);
    end
    build(8'h5A, 6, 1);
    run_req("after rst", 8'h5A, 4'd6,
            4'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
